model_tensor_feeder: RTL and testbench

- Upstream stage for the tensor algebra units (inverse, product, transpose).
- Buffers an I x J x K tensor that arrives as a flat element stream into local memory.
- Replays it element by element under downstream pull, with row/column/depth enable strobes in the codebase's DATA_*_ENABLE convention.
- Decouples producer timing from the iterative consumer, which stalls between elements.

---
 rtl/model_tensor_feeder.sv | 212 +++++++++++++++++++++
 tb/tb_model_tensor_feeder.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/model_tensor_feeder.sv
// model_tensor_feeder
//   Buffers an I x J x K tensor that arrives as a flat element stream, then
//   replays it one element per downstream ADVANCE. Each replayed element carries
//   slice (I), row (J) and element (K) strobes. The producer and the stalling
//   consumer are decoupled by the local buffer.
//   Optional feature: define TENSOR_FEEDER_TRANSPOSE_EN to add TRANSPOSE_IN.
//   When TRANSPOSE_IN is latched as 1, replay order becomes j (outer), i, k (inner).
// Ports:
//   CLK, RST              clock (rising edge), asynchronous active-low reset
//   START                 begin operation; sampled in IDLE only
//   SIZE_I/J/K_IN         tensor dimensions; latched at START
//   READY, ERROR          one-cycle end-of-operation pulse; ERROR=1 means the size was rejected
//   LOAD_ENABLE/DATA_IN   incoming element stream (LOAD phase only)
//   ADVANCE               downstream pull for the next element (STREAM phase only)
//   DATA_OUT(_ENABLE)     replayed element and its valid strobe
//   DATA_I/J/K_ENABLE     first-of-slice, first-of-row, per-element strobes
//   LENGTH_OUT            latched I*J*K; nonzero from LOAD until return to IDLE
//   TRANSPOSE_IN          (TENSOR_FEEDER_TRANSPOSE_EN only) j-outer replay order
module model_tensor_feeder #(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 4,
  parameter int unsigned ADDR_SIZE    = 6
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  output logic                 READY,
  output logic                 ERROR,
  input  logic [DATA_SIZE-1:0] SIZE_I_IN,
  input  logic [DATA_SIZE-1:0] SIZE_J_IN,
  input  logic [DATA_SIZE-1:0] SIZE_K_IN,
  input  logic                 LOAD_ENABLE,
  input  logic [DATA_SIZE-1:0] LOAD_DATA_IN,
  input  logic                 ADVANCE,
`ifdef TENSOR_FEEDER_TRANSPOSE_EN
  input  logic                 TRANSPOSE_IN,
`endif
  output logic                 DATA_OUT_ENABLE,
  output logic                 DATA_I_ENABLE,
  output logic                 DATA_J_ENABLE,
  output logic                 DATA_K_ENABLE,
  output logic [DATA_SIZE-1:0] LENGTH_OUT,
  output logic [DATA_SIZE-1:0] DATA_OUT
);

  localparam int unsigned          DEPTH   = 2 ** ADDR_SIZE;
  localparam logic [DATA_SIZE-1:0] DEPTH_W = DATA_SIZE'(DEPTH);
  localparam logic [ADDR_SIZE-1:0] ONE     = ADDR_SIZE'(1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM, S_FINISH} state_t;

  state_t               state_q, next_state;
  logic [DATA_SIZE-1:0] mem [DEPTH];
  logic [ADDR_SIZE-1:0] wr_ptr_q, rd_addr_q, last_addr_q;
  logic [ADDR_SIZE-1:0] j_q, k_q, j_max_q, k_max_q;
  logic [DATA_SIZE-1:0] total_c;
  logic                 size_ok_c, last_c, first_slice_c;
  logic                 accept_c, reject_c, wr_en_c, rd_en_c, done_c;

  // The control port width is part of the shared interface only.
  logic [CONTROL_SIZE-1:0] unused_ctrl_c;
  assign unused_ctrl_c = '0;

`ifdef TENSOR_FEEDER_TRANSPOSE_EN
  logic                 xpose_q;
  logic [ADDR_SIZE-1:0] i_q, i_max_q, row_step_q, wrap_step_q;
  logic [DATA_SIZE-1:0] jk_c;
  assign jk_c          = SIZE_J_IN * SIZE_K_IN;
  assign first_slice_c = xpose_q ? (i_q == '0 && k_q == '0) : (j_q == '0 && k_q == '0);
`else
  assign first_slice_c = (j_q == '0 && k_q == '0);
`endif

  // Size check on the live inputs so the reject pulse lands one cycle after START.
  always_comb begin
    total_c   = SIZE_I_IN * SIZE_J_IN * SIZE_K_IN;
    size_ok_c = (total_c != '0) && (total_c <= DEPTH_W);
  end

  // The final element always sits at address total-1 in either replay order.
  assign last_c = (rd_addr_q == last_addr_q);

  // State register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state_q;
    case (state_q)
      S_IDLE:   if (START && size_ok_c) next_state = S_LOAD;
      S_LOAD:   if (LOAD_ENABLE && wr_ptr_q == last_addr_q) next_state = S_STREAM;
      S_STREAM: if (ADVANCE && last_c) next_state = S_FINISH;
      S_FINISH: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Per-state datapath strobes
  always_comb begin
    accept_c = 1'b0;
    reject_c = 1'b0;
    wr_en_c  = 1'b0;
    rd_en_c  = 1'b0;
    done_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        accept_c = START && size_ok_c;
        reject_c = START && !size_ok_c;
      end
      S_LOAD:   wr_en_c = LOAD_ENABLE;
      S_STREAM: rd_en_c = ADVANCE;
      S_FINISH: done_c  = 1'b1;
      default: ;
    endcase
  end

  // Element buffer; contents survive reset.
  always_ff @(posedge CLK) begin
    if (wr_en_c) mem[wr_ptr_q] <= LOAD_DATA_IN;
  end

  // Registered outputs, loop counters and incremental read address
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      READY           <= 1'b0;
      ERROR           <= 1'b0;
      DATA_OUT_ENABLE <= 1'b0;
      DATA_I_ENABLE   <= 1'b0;
      DATA_J_ENABLE   <= 1'b0;
      DATA_K_ENABLE   <= 1'b0;
      LENGTH_OUT      <= '0;
      DATA_OUT        <= '0;
      wr_ptr_q        <= '0;
      rd_addr_q       <= '0;
      last_addr_q     <= '0;
      j_q             <= '0;
      k_q             <= '0;
      j_max_q         <= '0;
      k_max_q         <= '0;
`ifdef TENSOR_FEEDER_TRANSPOSE_EN
      xpose_q         <= 1'b0;
      i_q             <= '0;
      i_max_q         <= '0;
      row_step_q      <= '0;
      wrap_step_q     <= '0;
`endif
    end else begin
      READY           <= reject_c | done_c;
      ERROR           <= reject_c;
      DATA_OUT_ENABLE <= rd_en_c;
      DATA_K_ENABLE   <= rd_en_c;
      DATA_J_ENABLE   <= rd_en_c && (k_q == '0);
      DATA_I_ENABLE   <= rd_en_c && first_slice_c;
      if (accept_c) begin
        LENGTH_OUT  <= total_c;
        last_addr_q <= ADDR_SIZE'(total_c - DATA_SIZE'(1));
        j_max_q     <= ADDR_SIZE'(SIZE_J_IN - DATA_SIZE'(1));
        k_max_q     <= ADDR_SIZE'(SIZE_K_IN - DATA_SIZE'(1));
        wr_ptr_q    <= '0;
        rd_addr_q   <= '0;
        j_q         <= '0;
        k_q         <= '0;
`ifdef TENSOR_FEEDER_TRANSPOSE_EN
        xpose_q     <= TRANSPOSE_IN;
        i_q         <= '0;
        i_max_q     <= ADDR_SIZE'(SIZE_I_IN - DATA_SIZE'(1));
        // Step to the next i at fixed j: +J*K-(K-1). Wrap to the next j: -((I-1)*J*K-1).
        row_step_q  <= ADDR_SIZE'(jk_c - SIZE_K_IN + DATA_SIZE'(1));
        wrap_step_q <= ADDR_SIZE'(jk_c - total_c + DATA_SIZE'(1));
`endif
      end
      if (done_c) LENGTH_OUT <= '0;
      if (wr_en_c) wr_ptr_q <= wr_ptr_q + ONE;
      if (rd_en_c) begin
        DATA_OUT <= mem[rd_addr_q];
        if (k_q != k_max_q) begin
          k_q       <= k_q + ONE;
          rd_addr_q <= rd_addr_q + ONE;
        end else begin
          k_q <= '0;
`ifdef TENSOR_FEEDER_TRANSPOSE_EN
          if (xpose_q) begin
            if (i_q != i_max_q) begin
              i_q       <= i_q + ONE;
              rd_addr_q <= rd_addr_q + row_step_q;
            end else begin
              i_q       <= '0;
              j_q       <= j_q + ONE;
              rd_addr_q <= rd_addr_q + wrap_step_q;
            end
          end else
`endif
          begin
            rd_addr_q <= rd_addr_q + ONE;
            if (j_q != j_max_q) begin
              j_q <= j_q + ONE;
            end else begin
              j_q <= '0;
`ifdef TENSOR_FEEDER_TRANSPOSE_EN
              i_q <= i_q + ONE;
`endif
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_model_tensor_feeder.sv
// Bench for model_tensor_feeder: random load/advance timing against a
// nested-loop reference of the expected replay order and strobes.
module tb_model_tensor_feeder;

  localparam int unsigned DW = 64;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          ie;
    logic          je;
  } elem_t;

  logic          CLK;
  logic          RST;
  logic          START;
  logic          READY;
  logic          ERROR;
  logic [DW-1:0] SIZE_I_IN, SIZE_J_IN, SIZE_K_IN;
  logic          LOAD_ENABLE;
  logic [DW-1:0] LOAD_DATA_IN;
  logic          ADVANCE;
`ifdef TENSOR_FEEDER_TRANSPOSE_EN
  logic          TRANSPOSE_IN;
`endif
  logic          DATA_OUT_ENABLE, DATA_I_ENABLE, DATA_J_ENABLE, DATA_K_ENABLE;
  logic [DW-1:0] LENGTH_OUT;
  logic [DW-1:0] DATA_OUT;

  int            vectors;
  int            miscompares;
  logic [DW-1:0] ld [64];
  logic [DW-1:0] last_out;

  model_tensor_feeder #(
    .DATA_SIZE(DW), .CONTROL_SIZE(4), .ADDR_SIZE(6)
  ) dut (
    .CLK(CLK), .RST(RST), .START(START), .READY(READY), .ERROR(ERROR),
    .SIZE_I_IN(SIZE_I_IN), .SIZE_J_IN(SIZE_J_IN), .SIZE_K_IN(SIZE_K_IN),
    .LOAD_ENABLE(LOAD_ENABLE), .LOAD_DATA_IN(LOAD_DATA_IN), .ADVANCE(ADVANCE),
`ifdef TENSOR_FEEDER_TRANSPOSE_EN
    .TRANSPOSE_IN(TRANSPOSE_IN),
`endif
    .DATA_OUT_ENABLE(DATA_OUT_ENABLE), .DATA_I_ENABLE(DATA_I_ENABLE),
    .DATA_J_ENABLE(DATA_J_ENABLE), .DATA_K_ENABLE(DATA_K_ENABLE),
    .LENGTH_OUT(LENGTH_OUT), .DATA_OUT(DATA_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic quiet_inputs;
    START        = 1'b0;
    LOAD_ENABLE  = 1'b0;
    ADVANCE      = 1'b0;
    LOAD_DATA_IN = '0;
    SIZE_I_IN    = '0;
    SIZE_J_IN    = '0;
    SIZE_K_IN    = '0;
`ifdef TENSOR_FEEDER_TRANSPOSE_EN
    TRANSPOSE_IN = 1'b0;
`endif
  endtask

  task automatic test_reset;
    logic [5:0] got;
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    got = {READY, ERROR, DATA_OUT_ENABLE, DATA_I_ENABLE, DATA_J_ENABLE, DATA_K_ENABLE};
    vectors++;
    if (got !== 6'b0) begin
      miscompares++;
      $display("FAIL reset_strobes: got %b expected %b", got, 6'b0);
    end
    vectors++;
    if (LENGTH_OUT !== '0 || DATA_OUT !== '0) begin
      miscompares++;
      $display("FAIL reset_words: got len=%0h data=%0h expected 0/0", LENGTH_OUT, DATA_OUT);
    end
    @(negedge CLK);
    RST      = 1'b1;
    last_out = '0;
    @(posedge CLK);
    #1;
  endtask

  // One full START/LOAD/STREAM run. Inline checks cover every cycle against the reference.
  task automatic test_stream(input int ni, input int nj, input int nk, input bit xp,
                             input int load_pct, input int adv_pct, input int period);
    elem_t         exp_q[$];
    elem_t         e;
    int            n, wr, pres, cyc;
    bit            rp, done, exp_en, adv, le, exp_ready;
    logic [3:0]    got_f, exp_f;
    logic [DW-1:0] exp_len;
    n = ni * nj * nk;
    if (!xp) begin
      for (int i = 0; i < ni; i++)
        for (int j = 0; j < nj; j++)
          for (int k = 0; k < nk; k++)
            exp_q.push_back('{ld[(i*nj+j)*nk+k], (j == 0 && k == 0), (k == 0)});
    end else begin
      for (int j = 0; j < nj; j++)
        for (int i = 0; i < ni; i++)
          for (int k = 0; k < nk; k++)
            exp_q.push_back('{ld[(i*nj+j)*nk+k], (i == 0 && k == 0), (k == 0)});
    end

    SIZE_I_IN   = DW'(ni);
    SIZE_J_IN   = DW'(nj);
    SIZE_K_IN   = DW'(nk);
    START       = 1'b1;
    LOAD_ENABLE = 1'b0;
    ADVANCE     = 1'b0;
`ifdef TENSOR_FEEDER_TRANSPOSE_EN
    TRANSPOSE_IN = xp;
`endif
    @(posedge CLK);
    #1;
    START     = 1'b0;
    SIZE_I_IN = {$urandom, $urandom};
    SIZE_J_IN = {$urandom, $urandom};
    SIZE_K_IN = {$urandom, $urandom};
`ifdef TENSOR_FEEDER_TRANSPOSE_EN
    TRANSPOSE_IN = ~xp;
`endif
    vectors++;
    if (READY !== 1'b0 || LENGTH_OUT !== DW'(n)) begin
      miscompares++;
      $display("FAIL start_accept: got ready=%b len=%0d expected 0/%0d", READY, LENGTH_OUT, n);
    end

    wr = 0; pres = 0; rp = 0; done = 0;
    for (cyc = 0; cyc < 3000 && !done; cyc++) begin
      le = (wr < n) ? (int'($urandom_range(99)) < load_pct) : ($urandom_range(9) == 0);
      LOAD_ENABLE  = le;
      LOAD_DATA_IN = (le && wr < n) ? ld[wr] : {$urandom, $urandom};
      adv = (period > 0) ? (cyc % period == 0) : (int'($urandom_range(99)) < adv_pct);
      ADVANCE = adv;
      START   = ($urandom_range(19) == 0);
      exp_en  = adv && (wr == n) && (pres < n);
      @(posedge CLK);
      if (le && wr < n) wr++;
      #1;
      exp_ready = rp;
      rp = 0;
      vectors++;
      if (READY !== exp_ready || ERROR !== 1'b0) begin
        miscompares++;
        $display("FAIL ready_error cyc=%0d: got %b%b expected %b0", cyc, READY, ERROR, exp_ready);
      end
      if (exp_ready) done = 1;
      if (exp_en) begin
        e = exp_q[pres];
        pres++;
        if (pres == n) rp = 1;
        last_out = e.data;
        exp_f = {1'b1, e.ie, e.je, 1'b1};
      end else begin
        exp_f = 4'b0;
      end
      got_f = {DATA_OUT_ENABLE, DATA_I_ENABLE, DATA_J_ENABLE, DATA_K_ENABLE};
      vectors++;
      if (got_f !== exp_f) begin
        miscompares++;
        $display("FAIL enables cyc=%0d elem=%0d: got oe/i/j/k=%b expected %b", cyc, pres, got_f, exp_f);
      end
      vectors++;
      if (DATA_OUT !== last_out) begin
        miscompares++;
        $display("FAIL data_out cyc=%0d: got %0h expected %0h", cyc, DATA_OUT, last_out);
      end
      exp_len = done ? '0 : DW'(n);
      vectors++;
      if (LENGTH_OUT !== exp_len) begin
        miscompares++;
        $display("FAIL length_out cyc=%0d: got %0d expected %0d", cyc, LENGTH_OUT, exp_len);
      end
    end
    START       = 1'b0;
    LOAD_ENABLE = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL stream_timeout: got %0d of %0d elements, ready not seen", pres, n);
    end
    // Back in IDLE: a stray ADVANCE must produce nothing and READY must have dropped.
    ADVANCE = 1'b1;
    @(posedge CLK);
    #1;
    ADVANCE = 1'b0;
    vectors++;
    if ({READY, DATA_OUT_ENABLE} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_after_run: got ready/oe=%b%b expected 00", READY, DATA_OUT_ENABLE);
    end
  endtask

  task automatic test_size_reject;
    logic [DW-1:0] si [5];
    logic [DW-1:0] sj [5];
    logic [DW-1:0] sk [5];
    si[0] = 4;          sj[0] = 4;          sk[0] = 5;
    si[1] = 0;          sj[1] = 7;          sk[1] = 3;
    si[2] = 65;         sj[2] = 1;          sk[2] = 1;
    si[3] = 64'h1_0000_0000; sj[3] = 64'h1_0000_0000; sk[3] = 1;
    si[4] = 1;          sj[4] = 1;          sk[4] = 0;
    for (int t = 0; t < 5; t++) begin
      SIZE_I_IN = si[t];
      SIZE_J_IN = sj[t];
      SIZE_K_IN = sk[t];
      START     = 1'b1;
      @(posedge CLK);
      #1;
      START = 1'b0;
      vectors++;
      if ({READY, ERROR} !== 2'b11 || LENGTH_OUT !== '0) begin
        miscompares++;
        $display("FAIL reject_%0d: got ready/err=%b%b len=%0d expected 11 len=0", t, READY, ERROR, LENGTH_OUT);
      end
      for (int c = 0; c < 3; c++) begin
        LOAD_ENABLE  = 1'b1;
        LOAD_DATA_IN = {$urandom, $urandom};
        ADVANCE      = 1'b1;
        @(posedge CLK);
        #1;
        vectors++;
        if ({READY, ERROR, DATA_OUT_ENABLE} !== 3'b000 || LENGTH_OUT !== '0) begin
          miscompares++;
          $display("FAIL reject_idle_%0d: got ready/err/oe=%b%b%b len=%0d expected 000 len=0",
                   t, READY, ERROR, DATA_OUT_ENABLE, LENGTH_OUT);
        end
      end
      LOAD_ENABLE = 1'b0;
      ADVANCE     = 1'b0;
    end
  endtask

  task automatic test_abort_restart;
    logic [3:0] got;
    SIZE_I_IN = 2; SIZE_J_IN = 2; SIZE_K_IN = 2;
    START = 1'b1;
    @(posedge CLK);
    #1;
    START = 1'b0;
    for (int w = 0; w < 3; w++) begin
      LOAD_ENABLE  = 1'b1;
      LOAD_DATA_IN = DW'(w + 100);
      @(posedge CLK);
      #1;
    end
    LOAD_ENABLE = 1'b0;
    ADVANCE     = 1'b1;
    RST         = 1'b0;
    #1;
    got = {READY, ERROR, DATA_OUT_ENABLE, DATA_J_ENABLE};
    vectors++;
    if (got !== 4'b0 || LENGTH_OUT !== '0) begin
      miscompares++;
      $display("FAIL abort_async: got strobes=%b len=%0d expected 0000 len=0", got, LENGTH_OUT);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST      = 1'b1;
    ADVANCE  = 1'b0;
    last_out = '0;
    @(posedge CLK);
    #1;
    vectors++;
    if (READY !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_no_ready: got %b expected 0", READY);
    end
    ld[0] = 9;
    ld[1] = 10;
    test_stream(1, 1, 2, 1'b0, 100, 100, 0);
  endtask

  task automatic test_random_shapes;
    int ni, nj, nk;
    bit xp;
    for (int r = 0; r < 8; r++) begin
      ni = int'($urandom_range(1, 4));
      nj = int'($urandom_range(1, 4));
      nk = int'($urandom_range(1, 4));
      xp = 1'b0;
`ifdef TENSOR_FEEDER_TRANSPOSE_EN
      xp = $urandom_range(1) == 1;
`endif
      for (int a = 0; a < 64; a++) ld[a] = {$urandom, $urandom};
      test_stream(ni, nj, nk, xp, int'($urandom_range(30, 100)), int'($urandom_range(20, 100)), 0);
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    last_out    = '0;
    RST         = 1'b1;
    quiet_inputs();
    #2;
    test_reset();

    for (int a = 0; a < 8; a++) ld[a] = DW'(a + 1);
    test_stream(2, 2, 2, 1'b0, 100, 100, 0);

    for (int a = 0; a < 3; a++) ld[a] = {$urandom, $urandom};
    test_stream(1, 3, 1, 1'b0, 100, 0, 4);

    test_size_reject();

    for (int a = 0; a < 64; a++) ld[a] = {$urandom, $urandom};
    test_stream(4, 4, 4, 1'b0, 70, 60, 0);

    test_abort_restart();

`ifdef TENSOR_FEEDER_TRANSPOSE_EN
    for (int a = 0; a < 6; a++) ld[a] = DW'(a + 1);
    test_stream(2, 3, 1, 1'b1, 100, 100, 0);
`endif

    test_random_shapes();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
